// File: rtl/aes_pkg.sv
// AES-128 encrypt package: S-box, round-constant, GF(2^8) helpers, round-step
// functions and the FSM state type shared by the encrypt datapath.
// Optional feature macro used by the top: AES_RESTART_EN.
package aes_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDone} aes_state_e;

    localparam int unsigned NumRounds = 10;

    // Forward S-box, byte 0 in the most significant position.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] r;
        case (round)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Multiply by x modulo 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = sbox(s[127 - 8 * i -: 8]);
        return o;
    endfunction

    // Row r of column c takes the byte from column (c + r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) o[127 - 32 * c -: 32] = mix_column(s[127 - 32 * c -: 32]);
        return o;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_encrypt_top_key_round.sv
// Combinational AES-128 key-schedule step: derives round key K_r from K_{r-1}.
module aes_key_round
    import aes_pkg::*;
(
    input  logic [127:0] key_prev,
    input  logic [3:0]   round,
    output logic [127:0] key_next
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;

    // Word-wise expansion; RotWord is a left byte rotate of w3.
    always_comb begin
        w0 = key_prev[127:96];
        w1 = key_prev[95:64];
        w2 = key_prev[63:32];
        w3 = key_prev[31:0];
        n0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rcon(round), 24'h000000};
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        key_next = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_encrypt_top.sv
// Iterative AES-128 encryption core, one round per clock, on-the-fly key schedule.
// Optional feature macro: AES_RESTART_EN (a start strobe during RUN restarts the block).
module aes_encrypt_top
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,       // active-high synchronous reset despite the name
    input  logic [127:0] plain_text,
    input  logic [127:0] cipher_key,
    input  logic         cipher_new_en,
    output logic [127:0] cipher_text,
    output logic         cipher_ready
);

    aes_state_e   fsm_q;
    logic [127:0] state_q;
    logic [127:0] round_key_q;
    logic [3:0]   round_q;

    logic [127:0] key_next;
    logic [127:0] shifted;
    logic [127:0] round_out;
    logic         start;

    aes_key_round u_key_round (
        .key_prev (round_key_q),
        .round    (round_q),
        .key_next (key_next)
    );

    // Round datapath; the final round skips MixColumns.
    always_comb begin
        shifted   = shift_rows(sub_bytes(state_q));
        round_out = (round_q == 4'(NumRounds)) ? (shifted ^ key_next)
                                               : (mix_columns(shifted) ^ key_next);
    end

    // Start acceptance; without the restart feature a running block is never disturbed.
    always_comb begin
`ifdef AES_RESTART_EN
        start = cipher_new_en;
`else
        start = cipher_new_en && (fsm_q != StRun);
`endif
    end

    // FSM, state register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            fsm_q        <= StIdle;
            state_q      <= '0;
            round_key_q  <= '0;
            round_q      <= '0;
            cipher_text  <= '0;
            cipher_ready <= 1'b0;
        end else if (start) begin
            fsm_q        <= StRun;
            state_q      <= plain_text ^ cipher_key;
            round_key_q  <= cipher_key;
            round_q      <= 4'd1;
            cipher_ready <= 1'b0;
        end else if (fsm_q == StRun) begin
            state_q     <= round_out;
            round_key_q <= key_next;
            if (round_q == 4'(NumRounds)) begin
                cipher_text  <= round_out;
                cipher_ready <= 1'b1;
                fsm_q        <= StDone;
                round_q      <= '0;
            end else begin
                round_q <= round_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_encrypt_top.sv
// Self-checking bench for aes_encrypt_top: known-answer vectors plus multi-cycle sequences.
module tb_aes_encrypt_top;

    logic         clk;
    logic         reset_n;
    logic [127:0] plain_text;
    logic [127:0] cipher_key;
    logic         cipher_new_en;
    logic [127:0] cipher_text;
    logic         cipher_ready;

    int total;
    int bad;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [3];

    aes_encrypt_top dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .plain_text    (plain_text),
        .cipher_key    (cipher_key),
        .cipher_new_en (cipher_new_en),
        .cipher_text   (cipher_text),
        .cipher_ready  (cipher_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (independent byte-array AES) ----------------
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? (({x[6:0], 1'b0}) ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from the multiplicative inverse and the affine transform.
    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] inv, s, r;
        inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        s = inv;
        r = inv;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {m_sbox(tmp[31:24]) ^ rc, m_sbox(tmp[23:16]),
                       m_sbox(tmp[15:8]), m_sbox(tmp[7:0])};
                rc = m_mul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int j = 0; j < 16; j++) s[j] = pt[127 - 8 * j -: 8] ^ key[127 - 8 * j -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int j = 0; j < 16; j++) s[j] = m_sbox(s[j]);
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4 * c + r] = s[4 * ((c + r) % 4) + r];
            for (int j = 0; j < 16; j++) s[j] = t[j];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = m_mul(t[4*c], 8'h02) ^ m_mul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ m_mul(t[4*c+1], 8'h02) ^ m_mul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ m_mul(t[4*c+2], 8'h02) ^ m_mul(t[4*c+3], 8'h03);
                    s[4*c+3] = m_mul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ m_mul(t[4*c+3], 8'h02);
                end
            end
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4 * rnd + j / 4][31 - 8 * (j % 4) -: 8];
        end
        for (int j = 0; j < 16; j++) o[127 - 8 * j -: 8] = s[j];
        return o;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called #1 after an edge; the strobe is sampled on the next edge.
    task automatic start_block(input logic [127:0] k, input logic [127:0] p);
        cipher_key    = k;
        plain_text    = p;
        cipher_new_en = 1'b1;
        @(posedge clk);
        #1;
        cipher_new_en = 1'b0;
    endtask

    // Cycles until cipher_ready first seen high; -1 if the budget expires.
    task automatic wait_ready(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (cipher_ready) begin
                n = i;
                break;
            end
        end
    endtask

    logic [127:0] first_ct;
    logic [127:0] exp_a5;
    int           lat;
    int           ready_seen;

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{128'h0f1571c947d9e8590cb7add6af7f6798, 128'h0123456789abcdeffedcba9876543210,
                    128'hff0b844a0853bf7c6934ab4364148fb9};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32};

        reset_n       = 1'b1;
        cipher_new_en = 1'b0;
        plain_text    = '0;
        cipher_key    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 128'(cipher_ready), 128'd0);
        check("reset_text", cipher_text, 128'd0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;

        // Known-answer vectors.
        for (int v = 0; v < 3; v++) begin
            start_block(vecs[v].key, vecs[v].pt);
            wait_ready(lat);
            check($sformatf("vec%0d_latency", v), 128'(lat), 128'd10);
            check($sformatf("vec%0d_text", v), cipher_text, vecs[v].ct);
        end

        // Back-to-back: strobe in the first cycle of DONE.
        start_block(vecs[1].key, vecs[1].pt);
        wait_ready(lat);
        first_ct = cipher_text;
        check("b2b_first_text", first_ct, vecs[1].ct);
        exp_a5 = aes_model({16{8'ha5}}, 128'h00112233445566778899aabbccddeeff);
        start_block({16{8'ha5}}, 128'h00112233445566778899aabbccddeeff);
        check("b2b_ready_drop", 128'(cipher_ready), 128'd0);
        check("b2b_text_held", cipher_text, first_ct);
        wait_ready(lat);
        check("b2b_latency", 128'(lat), 128'd10);
        check("b2b_text", cipher_text, exp_a5);

`ifdef AES_RESTART_EN
        // Restart at round 4: only the second block's result appears.
        start_block(vecs[2].key, vecs[2].pt);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        start_block(vecs[1].key, vecs[1].pt);
        check("restart_ready_low", 128'(cipher_ready), 128'd0);
        wait_ready(lat);
        check("restart_latency", 128'(lat), 128'd10);
        check("restart_text", cipher_text, vecs[1].ct);
`else
        // Inputs and strobe changed during RUN are ignored.
        start_block(vecs[2].key, vecs[2].pt);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        start_block(vecs[1].key, vecs[1].pt);
        plain_text = '1;
        cipher_key = '1;
        wait_ready(lat);
        check("run_ignore_latency", 128'(lat + 4), 128'd10);
        check("run_ignore_text", cipher_text, vecs[2].ct);
`endif

        // DONE holds its result.
        first_ct = cipher_text;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("done_hold_ready", 128'(cipher_ready), 128'd1);
        check("done_hold_text", cipher_text, first_ct);

        // Reset at round 5 aborts the block.
        start_block(vecs[0].key, vecs[0].pt);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        check("abort_ready", 128'(cipher_ready), 128'd0);
        check("abort_text", cipher_text, 128'd0);
        ready_seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (cipher_ready) ready_seen++;
        end
        check("abort_no_ready", 128'(ready_seen), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
